// File: rtl/conv_input_streamer.sv
// conv_input_streamer: reads K_SIZE*K_SIZE kernel coefficients and then the image in raster
// order from a synchronous single-port RAM. The values are streamed to the conv_2d datapath
// over a valid/ready interface.
// Optional feature: define CONV_STREAM_ZERO_PAD_EN to emit a zero border of (K_SIZE-1)/2
// pixels around the image. Border beats issue no RAM read.
module conv_input_streamer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28,
    parameter int unsigned K_SIZE = 5,
    parameter int unsigned KBASE  = 0,
    parameter int unsigned IBASE  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] kernal_input,
    output logic              kernal_input_valid,
    output logic              kernal_complete,
    output logic [DATA_W-1:0] image_input_pixel,
    output logic              input_valid,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam int unsigned K2 = K_SIZE * K_SIZE;
`ifdef CONV_STREAM_ZERO_PAD_EN
    localparam int unsigned PAD = (K_SIZE - 1) / 2;
`else
    localparam int unsigned PAD = 0;
`endif
    localparam int unsigned PW    = IMG_W + 2 * PAD;
    localparam int unsigned PH    = IMG_H + 2 * PAD;
    localparam int unsigned TOTAL = K2 + PW * PH;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0]  K2_C     = CNT_W'(K2);
    localparam logic [CNT_W-1:0]  K2_LAST  = CNT_W'(K2 - 1);
    localparam logic [CNT_W-1:0]  TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] KBASE_A  = ADDR_W'(KBASE);
    localparam logic [ADDR_W-1:0] IBASE_A  = ADDR_W'(IBASE);

`ifdef CONV_STREAM_ZERO_PAD_EN
    localparam int unsigned CW = $clog2(PW + 1);
    localparam int unsigned RW = $clog2(PH + 1);
    localparam logic [CW-1:0] COL_LO   = CW'(PAD);
    localparam logic [CW-1:0] COL_HI   = CW'(PAD + IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
    localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI   = RW'(PAD + IMG_H);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StKload,
        StImage,
        StDone
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   rd_idx_q;
    logic [CNT_W-1:0]   acc_idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               busy_q;
    logic               kc_q;
    logic               fd_q;
`ifdef CONV_STREAM_ZERO_PAD_EN
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
`endif

    // Read in flight: data (or a zero border beat) arrives this cycle.
    logic               pend_q;
    logic               pend_k_q;
    logic               pend_z_q;
    // Output register and skid register, each tagged kernel/image.
    logic               out_v_q;
    logic               out_k_q;
    logic [DATA_W-1:0]  out_d_q;
    logic               skid_v_q;
    logic               skid_k_q;
    logic [DATA_W-1:0]  skid_d_q;

    logic               active;
    logic               accept;
    logic               issue;
    logic               k_phase;
    logic               border;
    logic [DATA_W-1:0]  arr_d;

    // Issue and handshake decode from registered state.
    always_comb begin
        active  = (state_q == StKload) || (state_q == StImage);
        accept  = out_v_q & out_ready;
        // One read per slot, only while the output register is free or draining.
        issue   = active && (rd_idx_q < TOTAL_C) && (!out_v_q || out_ready);
        k_phase = rd_idx_q < K2_C;
`ifdef CONV_STREAM_ZERO_PAD_EN
        border  = !k_phase && !((row_q >= ROW_LO) && (row_q < ROW_HI) &&
                                (col_q >= COL_LO) && (col_q < COL_HI));
`else
        border  = 1'b0;
`endif
        arr_d   = pend_z_q ? '0 : mem_rd_data;
    end

    // Output drive.
    always_comb begin
        mem_rd_en          = issue & ~border;
        mem_addr           = mem_rd_en ? addr_q : '0;
        busy               = busy_q;
        kernal_complete    = kc_q;
        frame_done         = fd_q;
        kernal_input_valid = out_v_q & out_k_q;
        input_valid        = out_v_q & ~out_k_q;
        kernal_input       = (out_v_q & out_k_q) ? out_d_q : '0;
        image_input_pixel  = (out_v_q & ~out_k_q) ? out_d_q : '0;
    end

    // Control FSM with read/accept counters, address counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_idx_q  <= '0;
            acc_idx_q <= '0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            kc_q      <= 1'b0;
            fd_q      <= 1'b0;
`ifdef CONV_STREAM_ZERO_PAD_EN
            col_q     <= '0;
            row_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    fd_q <= 1'b0;
                    if (start) begin
                        state_q   <= StKload;
                        busy_q    <= 1'b1;
                        rd_idx_q  <= '0;
                        acc_idx_q <= '0;
                        addr_q    <= KBASE_A;
`ifdef CONV_STREAM_ZERO_PAD_EN
                        col_q     <= '0;
                        row_q     <= '0;
`endif
                    end
                end
                StKload, StImage: begin
                    if (issue) begin
                        rd_idx_q <= rd_idx_q + CNT_W'(1);
                        if (k_phase) begin
                            // Jump straight to the image so the pixel stream follows with no gap.
                            addr_q <= (rd_idx_q == K2_LAST) ? IBASE_A : addr_q + ADDR_W'(1);
                        end else begin
                            if (!border) begin
                                addr_q <= addr_q + ADDR_W'(1);
                            end
`ifdef CONV_STREAM_ZERO_PAD_EN
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                row_q <= row_q + RW'(1);
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
`endif
                        end
                    end
                    if (accept) begin
                        acc_idx_q <= acc_idx_q + CNT_W'(1);
                        if ((state_q == StKload) && (acc_idx_q == K2_LAST)) begin
                            state_q <= StImage;
                            kc_q    <= 1'b1;
                        end
                        if ((state_q == StImage) && (acc_idx_q == LAST_C)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            kc_q    <= 1'b0;
                            fd_q    <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    fd_q    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Data path: landing read data into the output register, spilling to skid while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= 1'b0;
            pend_k_q <= 1'b0;
            pend_z_q <= 1'b0;
            out_v_q  <= 1'b0;
            out_k_q  <= 1'b0;
            out_d_q  <= '0;
            skid_v_q <= 1'b0;
            skid_k_q <= 1'b0;
            skid_d_q <= '0;
        end else begin
            pend_q   <= issue;
            pend_k_q <= k_phase;
            pend_z_q <= border;
            if (skid_v_q) begin
                // Skid holds the older beat, so it moves forward first.
                if (accept) begin
                    out_d_q <= skid_d_q;
                    out_k_q <= skid_k_q;
                    if (pend_q) begin
                        skid_d_q <= arr_d;
                        skid_k_q <= pend_k_q;
                    end else begin
                        skid_v_q <= 1'b0;
                    end
                end
            end else if (!out_v_q || accept) begin
                out_v_q <= pend_q;
                if (pend_q) begin
                    out_d_q <= arr_d;
                    out_k_q <= pend_k_q;
                end
            end else if (pend_q) begin
                skid_v_q <= 1'b1;
                skid_d_q <= arr_d;
                skid_k_q <= pend_k_q;
            end
        end
    end

endmodule

// File: tb/tb_conv_input_streamer.sv
// Directed bench for conv_input_streamer: 4x4 image, 3x3 kernel, mem[a] = a + 100.
module tb_conv_input_streamer;

`ifdef CONV_STREAM_ZERO_PAD_EN
    localparam int NP = 36;
`else
    localparam int NP = 16;
`endif
    localparam int NK = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, mem_rd_en, kv, kc, iv, frame_done;
    logic [15:0] mem_addr, kernal_input, image_input_pixel;
    logic [15:0] mem_rd_data = '0;

    conv_input_streamer #(
        .DATA_W(16), .ADDR_W(16), .IMG_W(4), .IMG_H(4), .K_SIZE(3), .KBASE(0), .IBASE(16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .busy               (busy),
        .mem_rd_en          (mem_rd_en),
        .mem_addr           (mem_addr),
        .mem_rd_data        (mem_rd_data),
        .kernal_input       (kernal_input),
        .kernal_input_valid (kv),
        .kernal_complete    (kc),
        .image_input_pixel  (image_input_pixel),
        .input_valid        (iv),
        .out_ready          (out_ready),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: data one cycle after the read strobe.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr + 16'd100;

    int checks = 0;
    int errors = 0;
    logic [15:0] kq[$];
    logic [15:0] pq[$];
    logic [15:0] exp_pix[$];
    int overlap, unstable, reads, img_reads, fd_cnt, kc_bad, done_bad, cyc, first_acc, last_acc;
    logic prev_hold = 1'b0;
    logic prev_k = 1'b0;
    logic [15:0] prev_data = '0;

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (kv && iv) overlap++;
        if (prev_hold && (prev_k ? !(kv && kernal_input == prev_data)
                                 : !(iv && image_input_pixel == prev_data))) unstable++;
        prev_hold = (kv || iv) && !out_ready && !rst;
        prev_k    = kv;
        prev_data = kv ? kernal_input : image_input_pixel;
        if (!rst) begin
            if (kv && out_ready) begin
                if (kq.size() == 0 && pq.size() == 0) first_acc = cyc;
                last_acc = cyc;
                kq.push_back(kernal_input);
                if (kc) kc_bad++;
            end
            if (iv && out_ready) begin
                last_acc = cyc;
                pq.push_back(image_input_pixel);
                if (!kc) kc_bad++;
            end
            if (mem_rd_en) begin
                reads++;
                if (mem_addr >= 16'd16) img_reads++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (busy || kc) done_bad++;
            end
        end
    end

    task automatic clear_mon();
        kq.delete();
        pq.delete();
        overlap = 0; unstable = 0; reads = 0; img_reads = 0; fd_cnt = 0;
        kc_bad = 0; done_bad = 0; first_acc = 0; last_acc = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // mode 1 toggles out_ready every cycle.
    task automatic wait_done(input int mode, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (mode == 1) out_ready = ~out_ready;
            if (frame_done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, mem_rd_en, kv, kc, iv, frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000000", {busy, mem_rd_en, kv, kc, iv, frame_done});
        end
        checks++;
        if ({mem_addr, kernal_input, image_input_pixel} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, kernal_input, image_input_pixel});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        checks++;
        if ({busy, mem_rd_en, kv} !== 3'b110 || mem_addr !== 16'd0) begin
            errors++;
            $display("FAIL t1_first_read: busy/rd/kv=%b addr=%0d want 110 addr 0",
                     {busy, mem_rd_en, kv}, mem_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (kv !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency_early: kv=%b want 0", kv);
        end
        @(posedge clk); #1;
        checks++;
        if (kv !== 1'b1 || kernal_input !== 16'd100) begin
            errors++;
            $display("FAIL t1_latency: kv=%b data=%0d want 1 100", kv, kernal_input);
        end
        wait_done(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_timeout: frame_done=0 want 1"); end
        checks++;
        if (busy !== 1'b0 || kc !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_state: busy=%b kc=%b want 0 0", busy, kc);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NK; i++) begin
            logic [15:0] got;
            got = (i < kq.size()) ? kq[i] : 16'hxxxx;
            checks++;
            if (got !== 16'(100 + i)) begin
                errors++;
                $display("FAIL t1_kern[%0d]: got %0d want %0d", i, got, 100 + i);
            end
        end
        for (int i = 0; i < NP; i++) begin
            logic [15:0] got;
            got = (i < pq.size()) ? pq[i] : 16'hxxxx;
            checks++;
            if (got !== exp_pix[i]) begin
                errors++;
                $display("FAIL t1_pix[%0d]: got %0d want %0d", i, got, exp_pix[i]);
            end
        end
        checks++;
        if (kq.size() != NK || pq.size() != NP) begin
            errors++;
            $display("FAIL t1_counts: got %0d/%0d want %0d/%0d", kq.size(), pq.size(), NK, NP);
        end
        checks++;
        if (last_acc - first_acc != NK + NP - 1) begin
            errors++;
            $display("FAIL t1_throughput: span %0d want %0d", last_acc - first_acc, NK + NP - 1);
        end
        checks++;
        if (kc_bad != 0 || overlap != 0 || done_bad != 0 || fd_cnt != 1) begin
            errors++;
            $display("FAIL t1_flags: kc_bad=%0d overlap=%0d done_bad=%0d fd=%0d want 0 0 0 1",
                     kc_bad, overlap, done_bad, fd_cnt);
        end
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: fd=%b busy=%b want 0 0", frame_done, busy);
        end
    endtask

    task automatic test_toggle();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        wait_done(1, ok);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL t2_timeout: frame_done=0 want 1"); end
        for (int i = 0; i < NK; i++) begin
            logic [15:0] got;
            got = (i < kq.size()) ? kq[i] : 16'hxxxx;
            checks++;
            if (got !== 16'(100 + i)) begin
                errors++;
                $display("FAIL t2_kern[%0d]: got %0d want %0d", i, got, 100 + i);
            end
        end
        for (int i = 0; i < NP; i++) begin
            logic [15:0] got;
            got = (i < pq.size()) ? pq[i] : 16'hxxxx;
            checks++;
            if (got !== exp_pix[i]) begin
                errors++;
                $display("FAIL t2_pix[%0d]: got %0d want %0d", i, got, exp_pix[i]);
            end
        end
        checks++;
        if (kq.size() != NK || pq.size() != NP || unstable != 0 || overlap != 0) begin
            errors++;
            $display("FAIL t2_stream: k=%0d p=%0d unstable=%0d overlap=%0d want %0d %0d 0 0",
                     kq.size(), pq.size(), unstable, overlap, NK, NP);
        end
    endtask

    task automatic test_stall();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (reads != 2 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL t3_read_cap: reads=%0d rd_en=%b want 2 0", reads, mem_rd_en);
        end
        checks++;
        if (kv !== 1'b1 || kernal_input !== 16'd100) begin
            errors++;
            $display("FAIL t3_hold: kv=%b data=%0d want 1 100", kv, kernal_input);
        end
        out_ready = 1'b1;
        wait_done(0, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL t3_timeout: frame_done=0 want 1"); end
        for (int i = 0; i < NK; i++) begin
            logic [15:0] got;
            got = (i < kq.size()) ? kq[i] : 16'hxxxx;
            checks++;
            if (got !== 16'(100 + i)) begin
                errors++;
                $display("FAIL t3_kern[%0d]: got %0d want %0d", i, got, 100 + i);
            end
        end
        for (int i = 0; i < NP; i++) begin
            logic [15:0] got;
            got = (i < pq.size()) ? pq[i] : 16'hxxxx;
            checks++;
            if (got !== exp_pix[i]) begin
                errors++;
                $display("FAIL t3_pix[%0d]: got %0d want %0d", i, got, exp_pix[i]);
            end
        end
        checks++;
        if (unstable != 0 || kq.size() != NK || pq.size() != NP) begin
            errors++;
            $display("FAIL t3_stream: unstable=%0d k=%0d p=%0d want 0 %0d %0d",
                     unstable, kq.size(), pq.size(), NK, NP);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 200 && pq.size() < 6; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pq.size() < 6) begin errors++; $display("FAIL t4_reach: pixels=%0d want 6", pq.size()); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, mem_rd_en, kv, kc, iv, frame_done} !== 6'b0 ||
            {mem_addr, kernal_input, image_input_pixel} !== 48'h0) begin
            errors++;
            $display("FAIL t4_abort: ctl=%b data=%h want 0",
                     {busy, mem_rd_en, kv, kc, iv, frame_done},
                     {mem_addr, kernal_input, image_input_pixel});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fd_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_no_done: fd=%0d busy=%b want 0 0", fd_cnt, busy);
        end
        clear_mon();
        pulse_start();
        wait_done(0, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL t4_timeout: frame_done=0 want 1"); end
        for (int i = 0; i < NK; i++) begin
            logic [15:0] got;
            got = (i < kq.size()) ? kq[i] : 16'hxxxx;
            checks++;
            if (got !== 16'(100 + i)) begin
                errors++;
                $display("FAIL t4_kern[%0d]: got %0d want %0d", i, got, 100 + i);
            end
        end
        for (int i = 0; i < NP; i++) begin
            logic [15:0] got;
            got = (i < pq.size()) ? pq[i] : 16'hxxxx;
            checks++;
            if (got !== exp_pix[i]) begin
                errors++;
                $display("FAIL t4_pix[%0d]: got %0d want %0d", i, got, exp_pix[i]);
            end
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();
        repeat (12) @(posedge clk);
        pulse_start();
        wait_done(0, ok);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL t5_timeout: frame_done=0 want 1"); end
        checks++;
        if (fd_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_one_done: fd=%0d busy=%b want 1 0", fd_cnt, busy);
        end
        checks++;
        if (kq.size() != NK || pq.size() != NP || reads != NK + 16) begin
            errors++;
            $display("FAIL t5_counts: k=%0d p=%0d reads=%0d want %0d %0d %0d",
                     kq.size(), pq.size(), reads, NK, NP, NK + 16);
        end
    endtask

    task automatic test_pad();
        bit ok;
        logic [15:0] row1[6];
        row1 = '{16'd0, 16'd116, 16'd117, 16'd118, 16'd119, 16'd0};
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        wait_done(0, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_timeout: frame_done=0 want 1"); end
        checks++;
        if (pq.size() != NP || img_reads != 16) begin
            errors++;
            $display("FAIL t6_counts: pixels=%0d img_reads=%0d want %0d 16", pq.size(), img_reads, NP);
        end
`ifdef CONV_STREAM_ZERO_PAD_EN
        for (int i = 0; i < 6; i++) begin
            logic [15:0] g0, g1;
            g0 = (i < pq.size()) ? pq[i] : 16'hxxxx;
            g1 = (i + 6 < pq.size()) ? pq[i + 6] : 16'hxxxx;
            checks++;
            if (g0 !== 16'd0) begin
                errors++;
                $display("FAIL t6_row0[%0d]: got %0d want 0", i, g0);
            end
            checks++;
            if (g1 !== row1[i]) begin
                errors++;
                $display("FAIL t6_row1[%0d]: got %0d want %0d", i, g1, row1[i]);
            end
        end
`else
        for (int i = 0; i < 4; i++) begin
            logic [15:0] g;
            g = (i < pq.size()) ? pq[i] : 16'hxxxx;
            checks++;
            if (g !== row1[i + 1]) begin
                errors++;
                $display("FAIL t6_row0[%0d]: got %0d want %0d", i, g, row1[i + 1]);
            end
        end
`endif
    endtask

    initial begin
        // Expected raster: interior pixel (r,c) = 116 + 4r + c; padded border is 0.
`ifdef CONV_STREAM_ZERO_PAD_EN
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                exp_pix.push_back((r >= 1 && r <= 4 && c >= 1 && c <= 4) ?
                                  16'(116 + 4 * (r - 1) + (c - 1)) : 16'd0);
`else
        for (int i = 0; i < 16; i++) exp_pix.push_back(16'(116 + i));
`endif
        clear_mon();
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_reset_mid();
        test_start_busy();
        test_pad();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
